// File: rtl/branch_predict_resolve_unit.sv
// branch_predict_resolve_unit
// Resolves conditional branches in EX and trains a bimodal table of
// saturating counters that supplies the fetch-stage prediction. Every
// misprediction raises a registered one-cycle redirect to the IF PC mux.
// Optional feature macro: BRU_STATS_EN adds stat_branches/stat_mispredicts.
module branch_predict_resolve_unit #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              res_branch,
    input  logic [5:0]        res_code,
    input  logic [DATA_W-1:0] res_op_a,
    input  logic [DATA_W-1:0] res_op_b,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_pred_taken,
    output logic              branch_taken,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [5:0] CODE_BEQ  = 6'h03;
    localparam logic [5:0] CODE_BNE  = 6'h04;
    localparam logic [5:0] CODE_BLEZ = 6'h07;
    localparam logic [5:0] CODE_BGTZ = 6'h0F;
    localparam logic [5:0] CODE_BGEZ = 6'h11;
    localparam logic [5:0] CODE_BLTZ = 6'h13;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);

    logic [CNT_W-1:0] bht [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             code_known;
    logic             outcome;
    logic             op_a_zero;
    logic             op_a_neg;
    logic             accept;
    logic             mispredict;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_next;
    logic [PC_W-1:0]  fix_pc;

    // Only the word-index bits of the fetch PC select a table entry.
    logic unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

    assign rd_idx     = pred_pc[IDX_W+1:2];
    assign wr_idx     = res_pc[IDX_W+1:2];
    assign pred_taken = bht[rd_idx][CNT_W-1];

    assign op_a_zero  = (res_op_a == '0);
    assign op_a_neg   = res_op_a[DATA_W-1];

    // Decode the branch code and evaluate the signed condition against zero or op_b.
    always_comb begin
        code_known = 1'b1;
        outcome    = 1'b0;
        case (res_code)
            CODE_BEQ:  outcome = (res_op_a == res_op_b);
            CODE_BNE:  outcome = (res_op_a != res_op_b);
            CODE_BLEZ: outcome = op_a_neg | op_a_zero;
            CODE_BGTZ: outcome = ~op_a_neg & ~op_a_zero;
            CODE_BGEZ: outcome = ~op_a_neg;
            CODE_BLTZ: outcome = op_a_neg;
            default:   code_known = 1'b0;
        endcase
    end

    // The instruction in EX while a redirect is out is wrong-path and is squashed.
    assign accept     = res_valid & res_branch & code_known & ~redirect_valid;
    assign mispredict = accept & (outcome != res_pred_taken);
    assign fix_pc     = outcome ? res_target : (res_pc + PC_STEP);

    // Saturating step of the counter being trained.
    always_comb begin
        cnt_cur  = bht[wr_idx];
        cnt_next = cnt_cur;
        if (outcome) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_ONE;
        end else begin
            if (cnt_cur != CNT_ZERO) cnt_next = cnt_cur - CNT_ONE;
        end
    end

    // Train the table on every accepted resolve; reset restores weakly not-taken everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (accept) begin
            bht[wr_idx] <= cnt_next;
        end
    end

    // Register the resolved outcome and the one-cycle redirect pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            branch_taken   <= accept & outcome;
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= fix_pc;
            end
        end
    end

`ifdef BRU_STATS_EN
    // Saturating event counters, updated on the same edge as the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// tb_branch_predict_resolve_unit
// Directed and randomized stimulus against a behavioural model of the
// branch resolver and its counter table; a monitor process checks each
// registered response popped from the expected-response queue.
module tb_branch_predict_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_branch;
    logic [5:0]  res_code;
    logic [31:0] res_op_a;
    logic [31:0] res_op_b;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic        branch_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predict_resolve_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_branch     (res_branch),
        .res_code       (res_code),
        .res_op_a       (res_op_a),
        .res_op_b       (res_op_b),
        .res_pc         (res_pc),
        .res_target     (res_target),
        .res_pred_taken (res_pred_taken),
        .branch_taken   (branch_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        bit          taken;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] nBr;
        logic [31:0] nMis;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state: plain integer counters per table entry.
    int          modelCnt [64];
    bit          modelRedirect;
    logic [31:0] modelBr;
    logic [31:0] modelMis;

    localparam logic [5:0] BEQ  = 6'h03;
    localparam logic [5:0] BNE  = 6'h04;
    localparam logic [5:0] BLEZ = 6'h07;
    localparam logic [5:0] BGTZ = 6'h0F;
    localparam logic [5:0] BGEZ = 6'h11;
    localparam logic [5:0] BLTZ = 6'h13;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tableIdx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) modelCnt[i] = 1;
        modelRedirect = 0;
        modelBr       = 0;
        modelMis      = 0;
    endfunction

    // Branch condition straight from the code table, using signed integer compares.
    function automatic bit evalBranch(input logic [5:0] code, input logic [31:0] a,
                                      input logic [31:0] b, output bit known);
        int sa;
        int sb;
        sa    = int'(a);
        sb    = int'(b);
        known = 1;
        case (code)
            BEQ:     return sa == sb;
            BNE:     return sa != sb;
            BLEZ:    return sa <= 0;
            BGTZ:    return sa > 0;
            BGEZ:    return sa >= 0;
            BLTZ:    return sa < 0;
            default: begin known = 0; return 0; end
        endcase
    endfunction

    // Drive one cycle of inputs, check the combinational prediction, then advance the model.
    task automatic applyStimulus(input bit valid, input bit branch, input logic [5:0] code,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] target,
                                 input bit predT, input logic [31:0] ppc);
        exp_t e;
        bit   known;
        bit   outc;
        bit   acc;
        bit   mis;
        int   k;
        @(negedge clk);
        res_valid      = valid;
        res_branch     = branch;
        res_code       = code;
        res_op_a       = a;
        res_op_b       = b;
        res_pc         = pc;
        res_target     = target;
        res_pred_taken = predT;
        pred_pc        = ppc;
        #1;
        checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, modelCnt[tableIdx(ppc)] >= 2});
        outc  = evalBranch(code, a, b, known);
        acc   = valid && branch && known && !modelRedirect;
        mis   = acc && (outc != predT);
        e.taken = acc && outc;
        e.rv    = mis;
        e.rpc   = outc ? target : pc + 32'd4;
        if (acc) begin
            k = tableIdx(pc);
            if (outc && modelCnt[k] < 3) modelCnt[k]++;
            else if (!outc && modelCnt[k] > 0) modelCnt[k]--;
            if (modelBr != 32'hFFFF_FFFF) modelBr++;
            if (mis && modelMis != 32'hFFFF_FFFF) modelMis++;
        end
        e.nBr  = modelBr;
        e.nMis = modelMis;
        modelRedirect = mis;
        expQ.push_back(e);
    endtask

    task automatic idle(input logic [31:0] ppc);
        applyStimulus(0, 0, 6'h00, 0, 0, 0, 0, 0, ppc);
    endtask

    // Pull reset low immediately; anything presented this cycle is lost.
    task automatic doReset();
        rst_n     = 1'b0;
        res_valid = 1'b0;
        expQ.delete();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after every rising edge, compare registered outputs with the next expected response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                checkOutput("reset branch_taken", {31'd0, branch_taken}, 32'd0);
                checkOutput("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
                checkOutput("reset redirect_pc", redirect_pc, 32'd0);
`ifdef BRU_STATS_EN
                checkOutput("reset stat_branches", stat_branches, 32'd0);
                checkOutput("reset stat_mispredicts", stat_mispredicts, 32'd0);
`endif
            end else if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
                checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
                if (e.rv) checkOutput("redirect_pc", redirect_pc, e.rpc);
`ifdef BRU_STATS_EN
                checkOutput("stat_branches", stat_branches, e.nBr);
                checkOutput("stat_mispredicts", stat_mispredicts, e.nMis);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0]  codes [7];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] ppc;
        bit          pt;

        codes = '{BEQ, BNE, BLEZ, BGTZ, BGEZ, BLTZ, 6'h05};
        rst_n = 1'b0;
        res_valid = 0; res_branch = 0; res_code = 0; res_op_a = 0; res_op_b = 0;
        res_pc = 0; res_target = 0; res_pred_taken = 0; pred_pc = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Every entry predicts not-taken after reset.
        for (int i = 0; i < 64; i++) idle(32'h100 + 32'(i * 4));

        // First taken BEQ with a not-taken prediction redirects to its target.
        applyStimulus(1, 1, BEQ, 5, 5, 32'h100, 32'h140, 0, 32'h100);
        idle(32'h100);
        applyStimulus(1, 1, BEQ, 7, 7, 32'h100, 32'h140, 1, 32'h100);
        applyStimulus(1, 1, BEQ, 7, 7, 32'h100, 32'h140, 1, 32'h100);
        idle(32'h100);
        applyStimulus(1, 1, BNE, 9, 9, 32'h100, 32'h140, 1, 32'h100);
        // Wrong-path branch in the redirect cycle must be ignored.
        applyStimulus(1, 1, BEQ, 1, 1, 32'h200, 32'h240, 0, 32'h200);
        idle(32'h200);
        applyStimulus(1, 1, BNE, 2, 2, 32'h200, 32'h240, 1, 32'h200);
        idle(32'h200);
        idle(32'h200);

        // Signed compares against zero.
        applyStimulus(1, 1, BLTZ, 32'hFFFF_FFFF, 0, 32'h300, 32'h380, 0, 32'h300);
        idle(32'h300);
        applyStimulus(1, 1, BGEZ, 32'hFFFF_FFFF, 0, 32'h304, 32'h380, 1, 32'h304);
        idle(32'h304);
        applyStimulus(1, 1, BLEZ, 0, 0, 32'h308, 32'h380, 0, 32'h308);
        idle(32'h308);
        applyStimulus(1, 1, BGTZ, 0, 0, 32'h30C, 32'h380, 1, 32'h30C);
        idle(32'h30C);
        // Unknown code and PC wrap on the fall-through redirect.
        applyStimulus(1, 1, 6'h05, 3, 3, 32'h310, 32'h380, 1, 32'h310);
        applyStimulus(1, 1, BNE, 4, 4, 32'hFFFF_FFFC, 32'h380, 1, 32'hFFFF_FFFC);
        idle(32'h0);

        // Reset while a mispredicting resolve is pending.
        applyStimulus(1, 1, BEQ, 6, 6, 32'h100, 32'h140, 0, 32'h100);
        #1;
        doReset();
        idle(32'h100);
        applyStimulus(1, 1, BEQ, 6, 6, 32'h100, 32'h140, 0, 32'h100);
        idle(32'h100);
        idle(32'h100);

        // Randomized traffic over a small set of indices to exercise saturation.
        for (int n = 0; n < 2000; n++) begin
            pc  = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            ppc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = 32'($signed($urandom_range(0, 6)) - 3);
                b = 32'($signed($urandom_range(0, 6)) - 3);
            end
            pt = ($urandom_range(0, 1) == 1) ? (modelCnt[tableIdx(pc)] >= 2) : bit'($urandom_range(0, 1));
            applyStimulus(bit'($urandom_range(0, 9) != 0), bit'($urandom_range(0, 9) != 0),
                          codes[$urandom_range(0, 6)], a, b, pc, $urandom & 32'hFFFF_FFFC, pt, ppc);
        end
        idle(32'h0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve_unit.md
# branch_predict_resolve_unit

Parametrised branch resolution unit with an integrated bimodal branch history table (BHT). Supplies a taken/not-taken prediction to fetch, resolves conditional branches in execute, trains a table of saturating counters, and raises a registered one-cycle redirect on every misprediction. It replaces the purely combinational resolver and sits between the EX stage and the IF-stage PC mux.

## Interface
- DATA_W, 32: width of the compared operands.
- PC_W, 32: width of the PC and branch targets.
- IDX_W, 6: BHT index width; the table holds 2^IDX_W entries.
- CNT_W, 2: width of each saturating counter; minimum 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_pc  in  PC_W  fetch PC to predict.
- pred_taken  out  1  combinational prediction: MSB of the counter at index pred_pc[IDX_W+1:2].
- res_valid  in  1  EX-stage instruction valid.
- res_branch  in  1  EX instruction is a conditional branch.
- res_code  in  6  branch code: BEQ 0x03, BNE 0x04, BLEZ 0x07, BGTZ 0x0F, BGEZ 0x11, BLTZ 0x13.
- res_op_a, res_op_b  in  DATA_W  compare operands; signed; only res_op_a is used for the zero compares.
- res_pc  in  PC_W  PC of the EX branch.
- res_target  in  PC_W  computed taken target.
- res_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- branch_taken  out  1  registered actual outcome.
- redirect_valid  out  1  registered one-cycle misprediction pulse.
- redirect_pc  out  PC_W  registered corrected PC; valid only while redirect_valid is 1.

## Operation
- A resolve is accepted when res_valid, res_branch, a known res_code, and !redirect_valid are all 1.
- Unknown codes cause no table update and produce branch_taken=0 and no redirect.
- Outcome:
  - BEQ: a==b.
  - BNE: a!=b.
  - BLEZ: a<=0.
  - BGTZ: a>0.
  - BGEZ: a>=0.
  - BLTZ: a<0.
  - All compares are signed.
- Table update on an accepted resolve, at index res_pc[IDX_W+1:2]:
  - taken: increment, saturating at 2^CNT_W-1.
  - not taken: decrement, saturating at 0.
- Misprediction is outcome != res_pred_taken.
  - Taken but predicted not-taken: redirect_pc = res_target.
  - Not taken but predicted taken: redirect_pc = res_pc+4, computed modulo 2^PC_W.
- Shadow squash: in the cycle where redirect_valid=1, the EX instruction is wrong-path. It is ignored: no update, no outputs, branch_taken=0 next cycle.
- Same-index read and update in one cycle: pred_taken shows the pre-update counter value. There is no bypass.

## Timing
- Resolve-to-output latency is 1 cycle. branch_taken, redirect_valid and redirect_pc are flops.
- pred_taken is combinational from pred_pc and the table, with zero latency.
- Back-to-back accepted branches are allowed every cycle. Each produces its own output the following cycle.
- redirect_valid is high for exactly one cycle per misprediction. There is no acknowledge.
- Reset values:
  - branch_taken=0, redirect_valid=0, redirect_pc=0.
  - Every counter = 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2).
- Reset asserted mid-operation clears the outputs and the whole table immediately, independent of clk. A resolve presented during reset is lost.

## Configuration
- BRU_STATS_EN defined: adds output ports stat_branches (32) and stat_mispredicts (32).
  - Both reset to 0.
  - stat_branches increments on each accepted resolve.
  - stat_mispredicts increments on each accepted misprediction.
  - Both saturate at 0xFFFFFFFF.
  - Both update in the same edge as the table.
- BRU_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then pred_pc=0x100 -> pred_taken=0 for every index. The first BEQ at pc 0x100 with a=b=5 and res_pred_taken=0 gives next cycle branch_taken=1, redirect_valid=1, redirect_pc=res_target=0x140.
- Two consecutive taken resolves at pc 0x100 -> counter saturates at 3 and pred_taken(0x100)=1. Then BNE with a=b, res_pred_taken=1 gives redirect_pc=0x104 and counter=2.
- Signed compares with a=0xFFFFFFFF:
  - BLTZ gives taken.
  - BGEZ gives not-taken.
  - BLEZ with a=0 gives taken.
  - BGTZ with a=0 gives not-taken.
- Mispredict at cycle N; at cycle N+1 present a taken BEQ at pc 0x200 with pred 0 -> ignored: no redirect at N+2 and the counter at 0x200 is unchanged.
- Assert rst_n=0 in the cycle after a resolve that would mispredict -> redirect_valid stays 0 and all counters return to 1. With BRU_STATS_EN, both stat counters read 0.
